// File: rtl/ecs8_input_debounce_pkg.sv
// Shared types and helpers for the input debounce block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ecs8_input_debounce_pkg;

    // Per-channel debounce state: settled on dout, or counting a candidate change.
    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_PEND   = 1'b1
    } ch_state_t;

    // Ceiling log2, evaluated at elaboration to size counters; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ecs8_input_debounce_if.sv
// Pad-side bundle of the debounce block: raw inputs, debounced levels, edge pulses.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a free-running level or single-cycle pulse.
interface ecs8_input_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;   // raw asynchronous pad levels
    logic [WIDTH-1:0] dout;  // debounced levels
    logic [WIDTH-1:0] rise;  // one-cycle pulse on accepted 0->1
    logic [WIDTH-1:0] fall;  // one-cycle pulse on accepted 1->0
    logic             evt;   // OR of all rise|fall bits, aligned with them

    // Pad / SOC side: drives the raw inputs, observes the debounced view.
    modport master (
        output din,
        input  dout,
        input  rise,
        input  fall,
        input  evt
    );

    // Debouncer side.
    modport slave (
        input  din,
        output dout,
        output rise,
        output fall,
        output evt
    );
endinterface

// File: rtl/ecs8_input_debounce_ch.sv
// One debounce channel: pad synchronizer, mismatch counter, 2-state FSM, edge pulses.
// Latency: SYNC_STAGES + 1 + between (DEBOUNCE-1)*PRESCALE+1 and DEBOUNCE*PRESCALE cycles pad to dout.
// Backpressure: none; a change must simply persist long enough to be accepted.
module ecs8_input_debounce_ch
    import ecs8_input_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE    = 1000,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic accept
);
    localparam int             CW       = clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    ch_state_t              state_q;
    ch_state_t              state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   dout_q;
    logic                   dout_d;
    logic                   rise_q;
    logic                   fall_q;

    assign sync = sync_q[SYNC_STAGES-1];

    // Metastability chain: the raw pad is only ever looked at through the last stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Next state: a mismatch is only timed once in PEND, so the entry cycle never counts a tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        accept  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (sync != dout_q) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (sync == dout_q) begin
                    // Input fell back before acceptance: treat as a glitch.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        accept  = 1'b1;
                        dout_d  = sync;
                        cnt_d   = '0;
                        state_d = ST_STABLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, level and pulse registers; the pulse is registered alongside the dout update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            dout_q  <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= accept & sync;
            fall_q  <= accept & ~sync;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/ecs8_input_debounce.sv
// Synchronizes and debounces WIDTH pad inputs, emitting rise/fall pulses and a combined event.
// Latency: SYNC_STAGES + 1 + (DEBOUNCE-1)*PRESCALE+1 .. DEBOUNCE*PRESCALE cycles pad to dout/pulse.
// Backpressure: none; pulses are single-cycle and not held for a consumer.
module ecs8_input_debounce
    import ecs8_input_debounce_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter int               PRESCALE    = 852,
    parameter int               DEBOUNCE    = 1000,
    parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ecs8_input_debounce_if.slave  io
);
    localparam int            PW       = clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre_q;
    logic             tick;
    logic [WIDTH-1:0] dout_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] accept_w;
    logic             evt_q;

    assign tick = (pre_q == PRE_LAST);

    // Shared debounce timebase: counts 0..PRESCALE-1, tick on the last count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            ecs8_input_debounce_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEBOUNCE    (DEBOUNCE),
                .RST_VAL     (RST_VAL[i])
            ) u_ch (
                .clk    (clk),
                .rst_n  (rst_n),
                .tick   (tick),
                .din    (io.din[i]),
                .dout   (dout_w[i]),
                .rise   (rise_w[i]),
                .fall   (fall_w[i]),
                .accept (accept_w[i])
            );
        end
    endgenerate

    // Combined event, built from the pre-register accepts so it lines up with rise/fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_q <= 1'b0;
        end else begin
            evt_q <= |accept_w;
        end
    end

    assign io.dout = dout_w;
    assign io.rise = rise_w;
    assign io.fall = fall_w;
    assign io.evt  = evt_q;

endmodule
